xillybus_rd_stream_src: RTL and testbench

// - Feeds one Xillybus host-read stream (user_r_*_32 port of the xillybus core) from an accelerator output.
// - The accelerator pushes 32-bit words through a valid/ready handshake; words are buffered in an internal FIFO.
// - The core pops the FIFO through the standard-FIFO rden/data/empty interface.
// - The accelerator's last flag becomes an end-of-file indication to the host.
// - Sits between an HLS kernel output and one read port of xillybus_core, in the bus_clk domain.

---
 rtl/xillybus_rd_stream_src.sv | 97 +++++++++
 tb/tb_xillybus_rd_stream_src.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/xillybus_rd_stream_src.sv
// Accelerator-to-Xillybus host-read bridge: valid/ready words are buffered in a
// FIFO that the core pops through rden/data/empty. The accelerator's last flag becomes user_eof.
module xillybus_rd_stream_src #(
  parameter int ADDR_W = 9
) (
  input  logic        bus_clk,
  input  logic        bus_rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic        user_rden,
  output logic [31:0] user_data,
  output logic        user_empty,
  output logic        user_eof,
  input  logic        user_open,
  output logic [31:0] words_sent
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, EOF} state_t;

  state_t state, state_nxt;

  logic [31:0]       mem_data [DEPTH];
  logic              mem_last [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;
  logic              push, pop;

  assign in_ready   = (state == STREAM) && (count != FULL);
  assign user_empty = (count == '0) || (state == IDLE);
  assign user_eof   = (state == EOF);

  // A closed device file flushes, so it also cancels any same-cycle push or pop.
  assign push = in_valid && in_ready && user_open;
  assign pop  = user_rden && !user_empty && user_open;

  always_comb begin
    state_nxt = state;
    if (!user_open) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = STREAM;
        STREAM:  if (push && in_last) state_nxt = DRAIN;
        DRAIN:   if (pop && mem_last[rd_ptr]) state_nxt = EOF;
        EOF:     state_nxt = EOF;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge bus_clk) begin
    if (!bus_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Storage carries no reset so it can map onto block RAM.
  always_ff @(posedge bus_clk) begin
    if (push) begin
      mem_data[wr_ptr] <= in_data;
      mem_last[wr_ptr] <= in_last;
    end
  end

  always_ff @(posedge bus_clk) begin
    if (!bus_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      user_data  <= '0;
      words_sent <= '0;
    end else if (!user_open) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop) begin
        user_data <= mem_data[rd_ptr];
        rd_ptr    <= rd_ptr + ADDR_W'(1);
      end
      // IDLE with user_open high is the open edge: start a fresh word tally.
      if (state == IDLE)  words_sent <= '0;
      else if (pop)       words_sent <= words_sent + 32'd1;
      case ({push, pop})
        2'b10:   count <= count + (ADDR_W + 1)'(1);
        2'b01:   count <= count - (ADDR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_xillybus_rd_stream_src.sv
// Directed and reference-queue checks for xillybus_rd_stream_src with a 4-deep FIFO.
module tb_xillybus_rd_stream_src;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        rden;
  logic [31:0] user_data;
  logic        user_empty;
  logic        user_eof;
  logic        user_open;
  logic [31:0] words_sent;

  int n_checks = 0;
  int n_errors = 0;

  xillybus_rd_stream_src #(.ADDR_W(2)) dut (
    .bus_clk    (clk),
    .bus_rst_n  (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .user_rden  (rden),
    .user_data  (user_data),
    .user_empty (user_empty),
    .user_eof   (user_eof),
    .user_open  (user_open),
    .words_sent (words_sent)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int          q[$];
  logic [31:0] prev;
  logic        acc, pp;
  int unsigned npop;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    rden = 1'b0; user_open = 1'b0;
    step(); step();
    check("rst_data",  user_data,  32'h0);
    check("rst_empty", user_empty, 32'h1);
    check("rst_eof",   user_eof,   32'h0);
    check("rst_ready", in_ready,   32'h0);
    check("rst_sent",  words_sent, 32'h0);

    rst_n = 1'b1; user_open = 1'b1;
    step();
    check("open_empty", user_empty, 32'h1);
    check("open_ready", in_ready,   32'h1);
    check("open_sent",  words_sent, 32'h0);

    // Fill to capacity, then offer the last word while full.
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 32'(i);
      step();
    end
    check("full_ready", in_ready, 32'h0);
    in_data = 32'd5; in_last = 1'b1; rden = 1'b1;
    step();
    check("pop1_data",  user_data, 32'd1);
    check("pop1_ready", in_ready,  32'h1);
    rden = 1'b0;
    step();
    check("drain_ready", in_ready, 32'h0);
    check("drain_eof",   user_eof, 32'h0);
    in_valid = 1'b0; in_last = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      rden = 1'b1;
      step();
      check($sformatf("order%0d", k), user_data, 32'(k));
      if (k < 5) check("eof_early", user_eof, 32'h0);
    end
    check("eof_set",   user_eof,   32'h1);
    check("eof_empty", user_empty, 32'h1);
    check("eof_sent",  words_sent, 32'd5);
    step();
    check("eof_hold",  user_eof,  32'h1);
    check("rden_empty_hold", user_data, 32'd5);
    rden = 1'b0;

    // Close, reopen, buffer three words, close again.
    user_open = 1'b0; step();
    check("close_eof", user_eof, 32'h0);
    user_open = 1'b1; step();
    check("reopen_sent", words_sent, 32'h0);
    in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data = 32'hA0 + 32'(i);
      step();
    end
    in_valid = 1'b0; user_open = 1'b0;
    step();
    check("drop_empty", user_empty, 32'h1);
    check("drop_ready", in_ready,   32'h0);
    check("drop_data",  user_data,  32'd5);
    user_open = 1'b1; step();
    check("reopen2_sent",  words_sent, 32'h0);
    check("reopen2_empty", user_empty, 32'h1);

    // Last word arriving into an empty FIFO with a concurrent rden.
    in_valid = 1'b1; in_data = 32'hB1; in_last = 1'b1; rden = 1'b1;
    step();
    check("lastpush_nopop",  user_data,  32'd5);
    check("lastpush_empty",  user_empty, 32'h0);
    check("lastpush_sent",   words_sent, 32'h0);
    in_valid = 1'b0; in_last = 1'b0;
    step();
    check("lastpop_data", user_data, 32'hB1);
    check("lastpop_eof",  user_eof,  32'h1);
    rden = 1'b0;

    // Random concurrent push/pop against a reference queue.
    user_open = 1'b0; step();
    user_open = 1'b1; step();
    prev = user_data;
    npop = 0;
    for (int c = 0; c < 1000; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      rden     = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      acc = in_valid && (q.size() < 4);
      pp  = rden && (q.size() > 0);
      if (pp) begin
        prev = 32'(q.pop_front());
        npop++;
      end
      if (acc) q.push_back(int'(in_data));
      step();
      check("rnd_data",  user_data,  prev);
      check("rnd_empty", user_empty, 32'(q.size() == 0));
      check("rnd_ready", in_ready,   32'(q.size() < 4));
    end
    check("rnd_sent", words_sent, 32'(npop));
    in_valid = 1'b0; rden = 1'b0;

    // Reset while draining: the transfer must never reach end of file.
    user_open = 1'b0; step();
    user_open = 1'b1; step();
    in_valid = 1'b1; in_data = 32'hC1; step();
    in_data = 32'hC2; in_last = 1'b1; step();
    in_valid = 1'b0; in_last = 1'b0;
    check("pre_rst_ready", in_ready, 32'h0);
    rst_n = 1'b0; step();
    rst_n = 1'b1;
    check("mrst_data",  user_data,  32'h0);
    check("mrst_empty", user_empty, 32'h1);
    check("mrst_eof",   user_eof,   32'h0);
    check("mrst_ready", in_ready,   32'h0);
    check("mrst_sent",  words_sent, 32'h0);
    rden = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("mrst_no_eof", user_eof,  32'h0);
      check("mrst_nodata", user_data, 32'h0);
    end
    rden = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
